// File: rtl/word_loader.sv
// Frame capture stage: debounces a load button, buffers DEPTH switch words, then
// streams them in capture order over a valid/ready link and counts non-one-hot words.
module word_loader #(
  parameter int WIDTH           = 16,
  parameter int DEPTH           = 8,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WIDTH-1:0]         sw,
  input  logic                     PB,
  input  logic                     clr,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last,
  output logic [$clog2(DEPTH):0]   fill_count,
  output logic [$clog2(DEPTH):0]   bad_count,
  output logic                     done,
  output logic [1:0]               dbg_state_o  // 0 = FILL, 1 = DRAIN, 2 = DONE
);

  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;
  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             sync1_q, sync2_q;
  logic [DBW-1:0]   db_cnt_q, db_cnt_d;
  logic             db_lvl_q, db_lvl_d;
  logic             load_pulse_q;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    fill_q, fill_d;
  logic [CW-1:0]    bad_q, bad_d;
  logic             mem_we;
  logic [WIDTH-1:0] mem_q [DEPTH];

  // The debounced level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_comb begin
    db_cnt_d = '0;
    db_lvl_d = db_lvl_q;
    if (sync2_q != db_lvl_q) begin
      if (db_cnt_q == DBW'(DEBOUNCE_CYCLES - 1)) begin
        db_lvl_d = sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  // Link protocol: a beat transfers on a cycle where out_valid && out_ready; once
  // raised, out_valid stays high with out_data/out_last frozen until that transfer.
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    bad_d    = bad_q;
    mem_we   = 1'b0;
    if (clr) begin
      state_d  = ST_FILL;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      fill_d   = '0;
      bad_d    = '0;
    end else begin
      case (state_q)
        ST_FILL: begin
          if (fill_q == CW'(DEPTH)) begin
            state_d = ST_DRAIN;
          end else if (load_pulse_q) begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            fill_d   = fill_q + 1'b1;
            if ($countones(sw) != 1) begin
              bad_d = bad_q + 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (out_ready) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            if (rd_ptr_q == PW'(DEPTH - 1)) begin
              state_d = ST_DONE;
            end
          end
        end
        ST_DONE: begin
          state_d = ST_DONE;
        end
        default: begin
          state_d = ST_FILL;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_FILL;
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      db_cnt_q     <= '0;
      db_lvl_q     <= 1'b0;
      load_pulse_q <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fill_q       <= '0;
      bad_q        <= '0;
    end else begin
      state_q      <= state_d;
      sync1_q      <= PB;
      sync2_q      <= sync1_q;
      db_cnt_q     <= db_cnt_d;
      db_lvl_q     <= db_lvl_d;
      load_pulse_q <= db_lvl_d & ~db_lvl_q;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fill_q       <= fill_d;
      bad_q        <= bad_d;
    end
  end

  // Buffer contents need no reset; they are only read after a full frame is written.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[wr_ptr_q] <= sw;
    end
  end

  assign out_valid   = (state_q == ST_DRAIN);
  assign out_data    = out_valid ? mem_q[rd_ptr_q] : '0;
  assign out_last    = out_valid && (rd_ptr_q == PW'(DEPTH - 1));
  assign done        = (state_q == ST_DONE);
  assign fill_count  = fill_q;
  assign bad_count   = bad_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_word_loader.sv
// Bench for word_loader: directed steps with random words, checked against a
// queue-based frame model and a link monitor.
module tb_word_loader;
  localparam int WIDTH = 16;
  localparam int DEPTH = 8;
  localparam int DEB   = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [WIDTH-1:0] sw = '0;
  logic             PB = 1'b0;
  logic             clr = 1'b0;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_last;
  logic [CW-1:0]    fill_count;
  logic [CW-1:0]    bad_count;
  logic             done;
  logic [1:0]       dbg_state_o;

  word_loader #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk(clk), .rst_n(rst_n), .sw(sw), .PB(PB), .clr(clr),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .fill_count(fill_count), .bad_count(bad_count),
    .done(done), .dbg_state_o(dbg_state_o)
  );

  always #5 clk = ~clk;

  int               n_checks = 0;
  int               n_errors = 0;
  logic [WIDTH-1:0] exp_q[$];
  int               exp_fill;
  int               exp_bad;
  bit               fill_phase;
  int               mon_beats;
  bit               hold_pending;
  bit               last_pending;
  logic [WIDTH-1:0] hold_data;
  logic             hold_last;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int ones(input logic [WIDTH-1:0] w);
    int n = 0;
    for (int i = 0; i < WIDTH; i++) n += int'(w[i]);
    return n;
  endfunction

  function automatic logic [WIDTH-1:0] rand_word();
    logic [WIDTH-1:0] w;
    if ($urandom_range(0, 1) == 1) w = WIDTH'(1) << $urandom_range(0, WIDTH - 1);
    else w = WIDTH'($urandom_range(0, 65535));
    return w;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    exp_fill     = 0;
    exp_bad      = 0;
    fill_phase   = 1'b1;
    mon_beats    = 0;
    hold_pending = 1'b0;
    last_pending = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // A clean press: the model decides whether the frame still accepts words.
  task automatic press(input logic [WIDTH-1:0] word, input int hold);
    if (fill_phase) begin
      exp_q.push_back(word);
      exp_fill++;
      if (ones(word) != 1) exp_bad++;
      if (exp_fill == DEPTH) fill_phase = 1'b0;
    end
    sw = word;
    PB = 1'b1;
    tick(hold);
    PB = 1'b0;
    tick(12);
    check("press_fill_count", 32'(fill_count), exp_fill);
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (!done && k < budget) begin
      tick(1);
      k++;
    end
    check("done_reached", 32'(done), 1);
  endtask

  task automatic wait_valid(input int budget);
    int k = 0;
    while (!out_valid && k < budget) begin
      tick(1);
      k++;
    end
    check("valid_reached", 32'(out_valid), 1);
  endtask

  task automatic clear_frame();
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    model_reset();
  endtask

  always @(negedge clk) begin
    if (rst_n && !clr) begin
      if (last_pending) begin
        check("done_after_last", 32'(done), 1);
        check("valid_after_last", 32'(out_valid), 0);
        check("last_after_last", 32'(out_last), 0);
        last_pending = 1'b0;
      end
      if (hold_pending) begin
        check("hold_valid", 32'(out_valid), 1);
        check("hold_data", 32'(out_data), 32'(hold_data));
        check("hold_last", 32'(out_last), 32'(hold_last));
      end
      if (out_valid && out_ready) begin
        check("beat_available", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) check("beat_data", 32'(out_data), 32'(exp_q.pop_front()));
        check("beat_last", 32'(out_last), 32'(mon_beats == DEPTH - 1));
        if (out_last) last_pending = 1'b1;
        mon_beats++;
      end
      hold_pending = out_valid && !out_ready;
      hold_data    = out_data;
      hold_last    = out_last;
    end else begin
      hold_pending = 1'b0;
      last_pending = 1'b0;
    end
  end

  initial begin
    logic [WIDTH-1:0] t1_words [DEPTH];
    int pat [6];
    int k;
    t1_words = '{16'h0000, 16'h8800, 16'h0100, 16'h8000, 16'h0001, 16'h0800, 16'h8110, 16'h0080};
    pat = '{1, 0, 0, 1, 0, 1};
    model_reset();

    // Reset state
    rst_n = 1'b0;
    tick(3);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_out_last", 32'(out_last), 0);
    check("rst_fill", 32'(fill_count), 0);
    check("rst_bad", 32'(bad_count), 0);
    check("rst_done", 32'(done), 0);
    check("rst_state", 32'(dbg_state_o), 0);
    rst_n = 1'b1;
    tick(2);

    // Fixed frame streamed with out_ready held high
    out_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) press(t1_words[i], 12);
    wait_done(100);
    check("t1_beats", mon_beats, DEPTH);
    check("t1_fill", 32'(fill_count), DEPTH);
    check("t1_bad", 32'(bad_count), exp_bad);
    check("t1_bad_const", 32'(bad_count), 3);

    // Press in DONE is ignored
    press(rand_word(), 12);
    check("done_press_bad", 32'(bad_count), exp_bad);
    check("done_press_done", 32'(done), 1);

    // clr in DONE returns to FILL
    clear_frame();
    check("clr_done", 32'(done), 0);
    check("clr_fill", 32'(fill_count), 0);
    check("clr_bad", 32'(bad_count), 0);
    check("clr_state", 32'(dbg_state_o), 0);

    // Short glitches never capture; a long hold captures once
    for (int g = 1; g < DEB; g++) begin
      sw = rand_word();
      PB = 1'b1;
      tick(g);
      PB = 1'b0;
      tick(10);
      check("glitch_fill", 32'(fill_count), 0);
    end
    press(rand_word(), 50);
    check("hold50_fill", 32'(fill_count), 1);

    // Fill the rest with backpressure; press while draining is ignored
    out_ready = 1'b0;
    for (int i = 1; i < DEPTH; i++) press(rand_word(), $urandom_range(12, 20));
    wait_valid(50);
    press(rand_word(), 12);
    check("drain_press_fill", 32'(fill_count), DEPTH);
    k = 0;
    while (!done && k < 200) begin
      out_ready = pat[k % 6] != 0;
      tick(1);
      k++;
    end
    out_ready = 1'b0;
    check("bp_done", 32'(done), 1);
    check("bp_beats", mon_beats, DEPTH);
    check("bp_bad", 32'(bad_count), exp_bad);

    // clr coinciding with a load pulse drops the word and clears the counters
    clear_frame();
    press(16'h0000, 12);
    press(rand_word(), 12);
    press(rand_word(), 12);
    check("pre_clr_fill", 32'(fill_count), 3);
    sw = rand_word();
    PB = 1'b1;
    clr = 1'b1;
    tick(12);
    clr = 1'b0;
    tick(3);
    PB = 1'b0;
    tick(12);
    model_reset();
    check("clr_pulse_fill", 32'(fill_count), 0);
    check("clr_pulse_bad", 32'(bad_count), 0);
    out_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) press(rand_word(), 12);
    wait_done(100);
    check("post_clr_beats", mon_beats, DEPTH);

    // Reset mid-drain after four beats, then a fresh frame
    clear_frame();
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) press(rand_word(), 12);
    wait_valid(50);
    out_ready = 1'b1;
    k = 0;
    while (mon_beats < 4 && k < 50) begin
      tick(1);
      k++;
    end
    check("mid_beats", mon_beats, 4);
    rst_n = 1'b0;
    out_ready = 1'b0;
    tick(2);
    check("mid_rst_valid", 32'(out_valid), 0);
    check("mid_rst_data", 32'(out_data), 0);
    check("mid_rst_last", 32'(out_last), 0);
    check("mid_rst_fill", 32'(fill_count), 0);
    check("mid_rst_bad", 32'(bad_count), 0);
    check("mid_rst_done", 32'(done), 0);
    check("mid_rst_state", 32'(dbg_state_o), 0);
    rst_n = 1'b1;
    model_reset();
    tick(2);
    out_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) press(rand_word(), 12);
    wait_done(100);
    check("post_rst_beats", mon_beats, DEPTH);
    check("post_rst_fill", 32'(fill_count), DEPTH);
    check("post_rst_bad", 32'(bad_count), exp_bad);
    tick(3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
